// File: rtl/fft_pkg.sv
// Shared types for the radix-2 FFT butterfly sequencer: FSM state encoding,
// packed complex sample layout and default sizing.
package fft_pkg;

   localparam int LOG2N_DEF = 3;
   localparam int DW_DEF    = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ     = 3'd1,
      LOAD     = 3'd2,
      ISSUE    = 3'd3,
      WAIT_RES = 3'd4,
      WRITE    = 3'd5,
      DONE     = 3'd6
   } state_t;

   typedef struct packed {
      logic signed [7:0] re;
      logic signed [7:0] im;
   } cplx_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address and twiddle generator for an in-place DIT FFT:
// (stage, k) -> operand pair addresses and twiddle index.
module fft_addr_gen #(
   parameter int LOG2N = fft_pkg::LOG2N_DEF
) (
   input  logic [LOG2N-1:0] i_stage,
   input  logic [LOG2N-2:0] i_k,
   output logic [LOG2N-1:0] o_addr_a,
   output logic [LOG2N-1:0] o_addr_b,
   output logic [LOG2N-2:0] o_tw
);

   logic [LOG2N-1:0] w_k;
   logic [LOG2N-1:0] w_half;
   logic [LOG2N-1:0] w_mask;

   always_comb begin
      w_k    = {1'b0, i_k};
      w_half = LOG2N'(1) << i_stage;
      w_mask = w_half - LOG2N'(1);
      // Insert a zero at bit position 'stage' of k to get the upper-half-free address.
      o_addr_a = ((w_k >> i_stage) << ({1'b0, i_stage} + 1'b1)) | (w_k & w_mask);
      o_addr_b = o_addr_a + w_half;
      o_tw     = (i_k & w_mask[LOG2N-2:0]) << (LOG2N'(LOG2N-1) - i_stage);
   end

endmodule

// File: rtl/fft_bfly_sequencer.sv
// In-place radix-2 DIT FFT sequencer driving one shared butterfly unit and a dual-port RAM.
// Build option FFT_SCALE_EN: request result halving from the butterfly on every issue.
module fft_bfly_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             mem_rd,
   output logic [LOG2N-1:0] mem_addr_a,
   output logic [LOG2N-1:0] mem_addr_b,
   input  logic [DW-1:0]    mem_rdata_a,
   input  logic [DW-1:0]    mem_rdata_b,
   output logic             mem_we,
   output logic [DW-1:0]    mem_wdata_a,
   output logic [DW-1:0]    mem_wdata_b,
   output logic             bf_valid,
   input  logic             bf_ready,
   output logic [DW-1:0]    bf_a,
   output logic [DW-1:0]    bf_b,
   output logic [LOG2N-2:0] bf_tw_idx,
   output logic             bf_scale,
   input  logic             bf_res_valid,
   input  logic [DW-1:0]    bf_sum,
   input  logic [DW-1:0]    bf_diff,
   output state_t           dbg_state
);

   state_t           r_state;
   logic [LOG2N-1:0] r_stage;
   logic [LOG2N-2:0] r_k;
   logic             r_busy, r_done, r_rd, r_we, r_valid;
   logic [LOG2N-1:0] r_addr_a, r_addr_b;
   logic [LOG2N-2:0] r_tw;
   logic [DW-1:0]    r_op_a, r_op_b, r_wdata_a, r_wdata_b;

   logic             w_last;
   logic [LOG2N-2:0] w_k_nxt, w_k_sel;
   logic [LOG2N-1:0] w_stage_nxt, w_stage_sel;
   logic [LOG2N-1:0] w_addr_a, w_addr_b;
   logic [LOG2N-2:0] w_tw;

   // In WRITE the generator already looks at the next butterfly so READ can start at once.
   always_comb begin
      w_last      = (r_stage == LOG2N'(LOG2N-1)) && (&r_k);
      w_k_nxt     = r_k + 1'b1;
      w_stage_nxt = r_stage;
      if (&r_k) w_stage_nxt = w_last ? '0 : r_stage + 1'b1;
      w_k_sel     = (r_state == WRITE) ? w_k_nxt : r_k;
      w_stage_sel = (r_state == WRITE) ? w_stage_nxt : r_stage;
   end

   fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .i_stage  (w_stage_sel),
      .i_k      (w_k_sel),
      .o_addr_a (w_addr_a),
      .o_addr_b (w_addr_b),
      .o_tw     (w_tw)
   );

   // Butterfly port: a pair transfers on the cycle bf_valid && bf_ready; bf_valid, bf_a,
   // bf_b and bf_tw_idx hold steady until then. bf_res_valid counts only in WAIT_RES.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_stage   <= '0;
         r_k       <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd      <= 1'b0;
         r_we      <= 1'b0;
         r_valid   <= 1'b0;
         r_addr_a  <= '0;
         r_addr_b  <= '0;
         r_tw      <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_wdata_a <= '0;
         r_wdata_b <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state  <= READ;
                  r_busy   <= 1'b1;
                  r_rd     <= 1'b1;
                  r_addr_a <= w_addr_a;
                  r_addr_b <= w_addr_b;
                  r_tw     <= w_tw;
               end
            end
            READ: begin
               r_rd    <= 1'b0;
               r_state <= LOAD;
            end
            LOAD: begin
               r_op_a  <= mem_rdata_a;
               r_op_b  <= mem_rdata_b;
               r_valid <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: begin
               if (bf_ready) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (bf_res_valid) begin
                  r_we      <= 1'b1;
                  r_wdata_a <= bf_sum;
                  r_wdata_b <= bf_diff;
                  r_state   <= WRITE;
               end
            end
            WRITE: begin
               r_we    <= 1'b0;
               r_k     <= w_k_nxt;
               r_stage <= w_stage_nxt;
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state  <= READ;
                  r_rd     <= 1'b1;
                  r_addr_a <= w_addr_a;
                  r_addr_b <= w_addr_b;
                  r_tw     <= w_tw;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign stage       = r_stage;
   assign mem_rd      = r_rd;
   assign mem_addr_a  = r_addr_a;
   assign mem_addr_b  = r_addr_b;
   assign mem_we      = r_we;
   assign mem_wdata_a = r_wdata_a;
   assign mem_wdata_b = r_wdata_b;
   assign bf_valid    = r_valid;
   assign bf_a        = r_op_a;
   assign bf_b        = r_op_b;
   assign bf_tw_idx   = r_tw;
   assign dbg_state   = r_state;

`ifdef FFT_SCALE_EN
   assign bf_scale = r_valid;
`else
   assign bf_scale = 1'b0;
`endif

endmodule
